// File: rtl/tp_fu_sequencer_if.sv
// Bus between the TP-FU sequencer and its host: program load, run control,
// and the instruction stream/status toward the FU.
interface tp_fu_sequencer_if #(
    parameter int INST_WIDTH     = 24,
    parameter int IMEM_ADDR_BITS = 6,
    parameter int ITER_BITS      = 16
);
    logic                      ld_en;
    logic [IMEM_ADDR_BITS-1:0] ld_addr;
    logic [INST_WIDTH-1:0]     ld_data;
    logic                      start;
    logic [IMEM_ADDR_BITS-1:0] prog_len;
    logic [ITER_BITS-1:0]      iter_count;
    logic                      abort;
    logic [INST_WIDTH-1:0]     inst;
    logic                      busy;
    logic                      done;
    logic [IMEM_ADDR_BITS-1:0] pc;

    modport master (
        output ld_en, ld_addr, ld_data, start, prog_len, iter_count, abort,
        input  inst, busy, done, pc
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, prog_len, iter_count, abort,
        output inst, busy, done, pc
    );
endinterface

// File: rtl/tp_fu_sequencer.sv
// Instruction sequencer feeding the TP-FU: loops a stored program, drains writeback, pulses done.
// Optional RAW-hazard stall scoreboard enabled by macro TP_SEQ_HAZARD_STALL_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus idle (NOP), program load allowed, waiting for start
// S_RUN   | issuing imem[pc] each cycle, looping until last iteration
// S_DRAIN | NOPs while FU writeback settles, then done pulse
module tp_fu_sequencer #(
    parameter int INST_WIDTH     = 24,
    parameter int IMEM_ADDR_BITS = 6,
    parameter int ITER_BITS      = 16,
    parameter int WB_LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tp_fu_sequencer_if.slave  bus_if
);

    localparam int IMEM_DEPTH = 2 ** IMEM_ADDR_BITS;
    localparam int DRAIN_BITS = $clog2(WB_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                    state_q, state_d;
    logic [INST_WIDTH-1:0]     inst_q, inst_d;
    logic [IMEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic [IMEM_ADDR_BITS-1:0] len_q, len_d;
    logic [ITER_BITS-1:0]      iter_q, iter_d;
    logic [ITER_BITS-1:0]      tgt_q, tgt_d;
    logic [DRAIN_BITS-1:0]     drain_q, drain_d;
    logic                      done_q, done_d;

    logic [INST_WIDTH-1:0]     imem_q [IMEM_DEPTH];
    logic [INST_WIDTH-1:0]     imem_rd;
    logic                      hazard;

    // No reset on the program store so a reset mid-run keeps the loaded program.
    always_ff @(posedge clk_i) begin
        if (bus_if.ld_en && state_q == S_IDLE) begin
            imem_q[bus_if.ld_addr] <= bus_if.ld_data;
        end
    end

    assign imem_rd = imem_q[pc_q];

`ifdef TP_SEQ_HAZARD_STALL_EN
    logic [WB_LATENCY-1:0]      sb_vld_q, sb_vld_d;
    logic [WB_LATENCY-1:0][5:0] sb_dst_q, sb_dst_d;
    logic [5:0]                 src1, src2;
    logic                       src2_used;
    logic                       issue_vld;

    assign src1      = imem_rd[11:6];
    assign src2      = imem_rd[5:0];
    assign src2_used = ~imem_rd[20];
    assign issue_vld = (state_q == S_RUN) && !bus_if.abort && !hazard && (imem_rd != '0);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LATENCY; i++) begin
            if (sb_vld_q[i] && src1 != 6'd0 && sb_dst_q[i] == src1) hazard = 1'b1;
            if (sb_vld_q[i] && src2_used && src2 != 6'd0 && sb_dst_q[i] == src2) hazard = 1'b1;
        end
    end

    // Entries age every cycle; a stall or NOP shifts in an invalid slot.
    always_comb begin
        sb_vld_d    = '0;
        sb_dst_d    = '0;
        sb_vld_d[0] = issue_vld;
        sb_dst_d[0] = imem_rd[17:12];
        for (int i = 1; i < WB_LATENCY; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_dst_d[i] = sb_dst_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_vld_q <= '0;
            sb_dst_q <= '0;
        end else begin
            sb_vld_q <= sb_vld_d;
            sb_dst_q <= sb_dst_d;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        inst_d  = '0;
        pc_d    = pc_q;
        len_d   = len_q;
        iter_d  = iter_q;
        tgt_d   = tgt_q;
        drain_d = drain_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    len_d   = bus_if.prog_len;
                    tgt_d   = (bus_if.iter_count == '0) ? ITER_BITS'(1) : bus_if.iter_count;
                    pc_d    = '0;
                    iter_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus_if.abort) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_BITS'(WB_LATENCY);
                end else if (!hazard) begin
                    inst_d = imem_rd;
                    if (pc_q == len_q) begin
                        pc_d   = '0;
                        iter_d = iter_q + ITER_BITS'(1);
                        // tgt_q is at least 1, so the subtraction cannot underflow.
                        if (iter_q == tgt_q - ITER_BITS'(1)) begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_BITS'(WB_LATENCY);
                        end
                    end else begin
                        pc_d = pc_q + IMEM_ADDR_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_BITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            iter_q  <= '0;
            tgt_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            iter_q  <= iter_d;
            tgt_q   <= tgt_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.inst = inst_q;
    assign bus_if.busy = (state_q != S_IDLE);
    assign bus_if.done = done_q;
    assign bus_if.pc   = pc_q;

endmodule

// File: tb/tb_tp_fu_sequencer.sv
// Randomized self-checking bench for tp_fu_sequencer against a cycle-list reference model.
// Hazard expectations follow TP_SEQ_HAZARD_STALL_EN when it is defined for the build.
module tb_tp_fu_sequencer;

    localparam int IW  = 24;
    localparam int AB  = 6;
    localparam int IB  = 16;
    localparam int WBL = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tp_fu_sequencer_if #(.INST_WIDTH(IW), .IMEM_ADDR_BITS(AB), .ITER_BITS(IB)) seq_if ();

    tp_fu_sequencer #(
        .INST_WIDTH(IW), .IMEM_ADDR_BITS(AB), .ITER_BITS(IB), .WB_LATENCY(WBL)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (seq_if)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IW-1:0] imem_m [2**AB];
    logic [IW-1:0] exp_bus [$];
    logic [IW-1:0] obs_bus [$];
    logic [IW-1:0] hist [$];

    localparam logic [IW-1:0] ADD_R5 = 24'h205042;  // r5 <- r1 + r2
    localparam logic [IW-1:0] SUB_R6 = 24'h406143;  // r6 <- r5 - r3

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef TP_SEQ_HAZARD_STALL_EN
    function automatic bit model_hazard(input logic [IW-1:0] c);
        bit hz = 1'b0;
        foreach (hist[i]) begin
            if (hist[i] != '0) begin
                if (c[11:6] != 6'd0 && c[11:6] == hist[i][17:12]) hz = 1'b1;
                if (!c[20] && c[5:0] != 6'd0 && c[5:0] == hist[i][17:12]) hz = 1'b1;
            end
        end
        return hz;
    endfunction
`endif

    task automatic model_push(input logic [IW-1:0] v);
        exp_bus.push_back(v);
        hist.push_back(v);
        if (hist.size() > WBL) void'(hist.pop_front());
    endtask

    // Expected bus contents after each issue edge, plus the edge that enters drain.
    task automatic build_model(input int plen, input int iters, input int abort_at, output int e);
        int n_it;
        n_it = (iters == 0) ? 1 : iters;
        exp_bus.delete();
        hist.delete();
        for (int i = 0; i < WBL; i++) hist.push_back('0);
        for (int it = 0; it < n_it; it++) begin
            for (int p = 0; p <= plen; p++) begin
`ifdef TP_SEQ_HAZARD_STALL_EN
                while (model_hazard(imem_m[p])) model_push('0);
`endif
                model_push(imem_m[p]);
            end
        end
        if (abort_at >= 1 && abort_at <= exp_bus.size()) begin
            while (exp_bus.size() > abort_at - 1) void'(exp_bus.pop_back());
            e = abort_at;
        end else begin
            e = exp_bus.size();
        end
    endtask

    task automatic load_word(input int a, input logic [IW-1:0] d);
        seq_if.ld_en   = 1'b1;
        seq_if.ld_addr = AB'(a);
        seq_if.ld_data = d;
        @(negedge clk);
        seq_if.ld_en   = 1'b0;
        imem_m[a]      = d;
    endtask

    task automatic clear_inputs();
        seq_if.ld_en      = 1'b0;
        seq_if.ld_addr    = '0;
        seq_if.ld_data    = '0;
        seq_if.start      = 1'b0;
        seq_if.abort      = 1'b0;
        seq_if.prog_len   = '0;
        seq_if.iter_count = '0;
    endtask

    // abort_at / inject_at: edge index (start edge = 0) at which the pulse is sampled; -1 = none.
    task automatic run_seq(input int plen, input int iters, input int abort_at,
                           input int inject_at, input string tag);
        int            e;
        int            done_k;
        logic [IW-1:0] exp_inst;
        build_model(plen, iters, abort_at, e);
        obs_bus.delete();
        done_k            = -1;
        seq_if.prog_len   = AB'(plen);
        seq_if.iter_count = IB'(iters);
        seq_if.start      = 1'b1;
        seq_if.abort      = (abort_at == 0);
        for (int k = 0; k <= e + 5; k++) begin
            @(negedge clk);
            exp_inst = (k >= 1 && k <= exp_bus.size()) ? exp_bus[k-1] : '0;
            check_eq($sformatf("%s inst k%0d", tag, k), 32'(seq_if.inst), 32'(exp_inst));
            check_eq($sformatf("%s busy k%0d", tag, k), 32'(seq_if.busy), 32'(k < e + 4));
            check_eq($sformatf("%s done k%0d", tag, k), 32'(seq_if.done), 32'(k == e + 4));
            if (seq_if.done === 1'b1 && done_k < 0) done_k = k;
            if (k >= 1) obs_bus.push_back(seq_if.inst);
            seq_if.start   = (k + 1 == inject_at);
            seq_if.ld_en   = (k + 1 == inject_at);
            seq_if.ld_addr = '0;
            seq_if.ld_data = imem_m[0] ^ 24'hFFFFFF;
            seq_if.abort   = (k + 1 == abort_at);
        end
        check_eq({tag, " done cycle"}, 32'(done_k), 32'(e + 4));
        clear_inputs();
    endtask

    initial begin
        int ia;
        int is;
        int plen;
        int iters;
        int ab;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_eq("reset inst", 32'(seq_if.inst), 32'h0);
        check_eq("reset busy", 32'(seq_if.busy), 32'h0);
        check_eq("reset done", 32'(seq_if.done), 32'h0);
        check_eq("reset pc",   32'(seq_if.pc),   32'h0);
        rst = 1'b0;
        @(negedge clk);

        load_word(0, 24'h3A1C07);
        load_word(1, 24'h12F0C3);
        load_word(2, 24'h5B2E44);
        load_word(3, 24'h7F0181);
        run_seq(3, 2, -1, -1, "basic");
        run_seq(0, 0, -1, -1, "single");
        run_seq(3, 1, 0, -1, "start_abort");

        for (int i = 4; i < 10; i++) load_word(i, IW'($urandom));
        run_seq(9, 1, 2, -1, "abort");

        run_seq(3, 2, -1, 3, "inject");
        run_seq(3, 1, -1, -1, "post_inject");

        // Asynchronous reset landing between clock edges in the middle of a run.
        seq_if.prog_len   = AB'(3);
        seq_if.iter_count = IB'(2);
        seq_if.start      = 1'b1;
        @(negedge clk);
        seq_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst busy", 32'(seq_if.busy), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst inst", 32'(seq_if.inst), 32'h0);
        check_eq("mid_rst busy", 32'(seq_if.busy), 32'h0);
        check_eq("mid_rst done", 32'(seq_if.done), 32'h0);
        check_eq("mid_rst pc",   32'(seq_if.pc),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        run_seq(3, 2, -1, -1, "replay");

        load_word(0, ADD_R5);
        load_word(1, SUB_R6);
        run_seq(1, 1, -1, -1, "hazard");
        ia = -1;
        is = -1;
        foreach (obs_bus[i]) begin
            if (obs_bus[i] == ADD_R5 && ia < 0) ia = i;
            if (obs_bus[i] == SUB_R6 && is < 0) is = i;
        end
`ifdef TP_SEQ_HAZARD_STALL_EN
        check_eq("hazard gap", 32'(is - ia - 1), 32'd3);
`else
        check_eq("hazard gap", 32'(is - ia - 1), 32'd0);
`endif

        for (int r = 0; r < 10; r++) begin
            plen  = $urandom_range(0, 7);
            iters = $urandom_range(0, 3);
            for (int p = 0; p <= plen; p++) begin
                load_word(p, ($urandom_range(0, 5) == 0) ? '0 : IW'($urandom));
            end
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (plen + 1) * (iters + 1)) : -1;
            run_seq(plen, iters, ab, -1, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
